// File: rtl/fu_wb_scheduler.sv
// rtl/fu_wb_scheduler.sv - per-lane timing-wheel writeback/wakeup scheduler with busy tracking
// Optional early (one-cycle-ahead) wakeup hint enabled by defining RS_EARLY_WAKEUP_EN.
module fu_wb_scheduler #(
  parameter int                       ISSUE_WIDTH = 4,
  parameter int                       PRF_WIDTH   = 7,
  parameter logic [4*ISSUE_WIDTH-1:0] LANE_LAT    = {ISSUE_WIDTH{4'd1}},
  parameter logic [ISSUE_WIDTH-1:0]   LANE_PIPE   = {ISSUE_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_flush,
  input  logic [ISSUE_WIDTH-1:0] issue_valid,
  input  logic [ISSUE_WIDTH-1:0] issue_dest_valid,
  input  logic [PRF_WIDTH-1:0]   issue_dest_prn [0:ISSUE_WIDTH-1],
  output logic [ISSUE_WIDTH-1:0] lane_ready,
  output logic [ISSUE_WIDTH-1:0] writeback_valid,
  output logic [PRF_WIDTH-1:0]   writeback_prn [0:ISSUE_WIDTH-1],
  output logic [ISSUE_WIDTH-1:0] early_wb_valid,
  output logic [PRF_WIDTH-1:0]   early_wb_prn [0:ISSUE_WIDTH-1]
);

  localparam int SLOTS = 15;

  genvar gl;
  generate
    for (gl = 0; gl < ISSUE_WIDTH; gl++) begin : g_lane
      localparam logic [3:0] LAT_ENC = LANE_LAT[4*gl +: 4];
      // An encoded latency of 0 behaves as a single-cycle lane.
      localparam int         LAT     = (LAT_ENC == 4'd0) ? 1 : int'(LAT_ENC);

      logic [SLOTS-1:0]     slot_valid;
      logic [PRF_WIDTH-1:0] slot_prn [SLOTS];
      logic                 accept;

      assign accept = issue_valid[gl] & lane_ready[gl] & ~pipe_flush;

      // Slot k means "writes back k cycles from now"; the wheel advances every edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid <= '0;
          for (int k = 0; k < SLOTS; k++) begin
            slot_prn[k] <= '0;
          end
        end else begin
          for (int k = 0; k < SLOTS-1; k++) begin
            slot_valid[k] <= slot_valid[k+1] & ~pipe_flush;
            slot_prn[k]   <= slot_prn[k+1];
          end
          slot_valid[SLOTS-1] <= 1'b0;
          if (accept) begin
            slot_valid[LAT-1] <= issue_dest_valid[gl];
            slot_prn[LAT-1]   <= issue_dest_prn[gl];
          end
        end
      end

      assign writeback_valid[gl] = slot_valid[0];
      assign writeback_prn[gl]   = slot_prn[0];

`ifdef RS_EARLY_WAKEUP_EN
      assign early_wb_valid[gl] = slot_valid[1];
      assign early_wb_prn[gl]   = slot_prn[1];
`else
      assign early_wb_valid[gl] = 1'b0;
      assign early_wb_prn[gl]   = '0;
`endif

      if (LANE_PIPE[gl]) begin : g_pipe
        assign lane_ready[gl] = 1'b1;
      end else begin : g_npipe
        logic [3:0] busy_cnt;

        // Counter reaches 0 in the same cycle the op writes back, allowing back-to-back issue.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            busy_cnt <= 4'd0;
          end else if (pipe_flush) begin
            busy_cnt <= 4'd0;
          end else if (accept) begin
            busy_cnt <= 4'(LAT - 1);
          end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
          end
        end

        assign lane_ready[gl] = (busy_cnt == 4'd0);
      end
    end
  endgenerate

endmodule

// File: tb/tb_fu_wb_scheduler.sv
// tb/tb_fu_wb_scheduler.sv - scoreboard bench for fu_wb_scheduler
module tb_fu_wb_scheduler;
  localparam int IW = 5;
  localparam int PW = 6;
  // Lane 4 is encoded as latency 0 and must behave as latency 1.
  localparam int LAT  [IW] = '{3, 4, 5, 2, 1};
  localparam int PIPE [IW] = '{1, 0, 1, 0, 1};

  logic          clk;
  logic          rst_n;
  logic          pipe_flush;
  logic [IW-1:0] issue_valid;
  logic [IW-1:0] issue_dest_valid;
  logic [PW-1:0] issue_dest_prn [0:IW-1];
  logic [IW-1:0] lane_ready;
  logic [IW-1:0] writeback_valid;
  logic [PW-1:0] writeback_prn [0:IW-1];
  logic [IW-1:0] early_wb_valid;
  logic [PW-1:0] early_wb_prn [0:IW-1];

  fu_wb_scheduler #(
    .ISSUE_WIDTH (IW),
    .PRF_WIDTH   (PW),
    .LANE_LAT    ({4'd0, 4'd2, 4'd5, 4'd4, 4'd3}),
    .LANE_PIPE   (5'b10101)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_flush       (pipe_flush),
    .issue_valid      (issue_valid),
    .issue_dest_valid (issue_dest_valid),
    .issue_dest_prn   (issue_dest_prn),
    .lane_ready       (lane_ready),
    .writeback_valid  (writeback_valid),
    .writeback_prn    (writeback_prn),
    .early_wb_valid   (early_wb_valid),
    .early_wb_prn     (early_wb_prn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int cyc;
    int kind;
    int prn;
  } ev_t;

  ev_t sb [$];
  int  busy_until [IW];
  int  cyc;
  int  checks;
  int  failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int find_ev(input int l, input int c, input int k);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].lane == l && sb[i].cyc == c && sb[i].kind == k) return i;
    end
    return -1;
  endfunction

  function automatic bit model_ready(input int l);
    return (PIPE[l] != 0) || (cyc >= busy_until[l]);
  endfunction

  task automatic compare_outputs();
    for (int l = 0; l < IW; l++) begin
      int idx;
      check($sformatf("lane_ready[%0d]", l), lane_ready[l], model_ready(l));
      idx = find_ev(l, cyc, 0);
      check($sformatf("wb_valid[%0d]", l), writeback_valid[l], (idx >= 0));
      if (idx >= 0) begin
        check($sformatf("wb_prn[%0d]", l), writeback_prn[l], sb[idx].prn);
        sb.delete(idx);
      end
`ifdef RS_EARLY_WAKEUP_EN
      idx = find_ev(l, cyc, 1);
      check($sformatf("early_valid[%0d]", l), early_wb_valid[l], (idx >= 0));
      if (idx >= 0) begin
        check($sformatf("early_prn[%0d]", l), early_wb_prn[l], sb[idx].prn);
        sb.delete(idx);
      end
`else
      check($sformatf("early_valid[%0d]", l), early_wb_valid[l], 0);
      check($sformatf("early_prn[%0d]", l), early_wb_prn[l], 0);
`endif
    end
  endtask

  task automatic drive(input int l, input int p, input bit dv);
    issue_valid[l]      = 1'b1;
    issue_dest_valid[l] = dv;
    issue_dest_prn[l]   = PW'(p);
  endtask

  task automatic apply_stimulus();
    pipe_flush       = 1'b0;
    issue_valid      = '0;
    issue_dest_valid = '0;
    for (int l = 0; l < IW; l++) issue_dest_prn[l] = '0;
    case (cyc)
      30: begin drive(0, 5, 1); drive(1, 9, 1); end
      31: drive(0, 6, 1);
      32: begin drive(0, 7, 1); drive(1, 20, 1); end
      34: drive(1, 10, 1);
      40: begin drive(4, 11, 1); drive(3, 12, 1); end
      41: begin drive(4, 14, 1); drive(3, 13, 1); end
      42: drive(3, 15, 1);
      50: drive(0, 12, 1);
      60: drive(2, 3, 1);
      61: drive(1, 22, 1);
      62: begin pipe_flush = 1'b1; drive(2, 4, 1); end
      80: drive(3, 63, 0);
      90: begin drive(0, 30, 1); drive(2, 31, 1); drive(1, 32, 1); end
      default: begin
        if (cyc >= 100 && cyc < 400) begin
          pipe_flush = ($urandom_range(0, 15) == 0);
          for (int l = 0; l < IW; l++) begin
            if ($urandom_range(0, 1) == 1) drive(l, int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0));
          end
        end
      end
    endcase
  endtask

  task automatic model_update();
    for (int l = 0; l < IW; l++) begin
      if (issue_valid[l] && model_ready(l) && !pipe_flush) begin
        if (issue_dest_valid[l]) begin
          sb.push_back('{lane: l, cyc: cyc + LAT[l], kind: 0, prn: int'(issue_dest_prn[l])});
`ifdef RS_EARLY_WAKEUP_EN
          if (LAT[l] >= 2) sb.push_back('{lane: l, cyc: cyc + LAT[l] - 1, kind: 1, prn: int'(issue_dest_prn[l])});
`endif
        end
        if (PIPE[l] == 0) busy_until[l] = cyc + LAT[l];
      end
    end
    if (pipe_flush) begin
      sb.delete();
      for (int l = 0; l < IW; l++) busy_until[l] = 0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int l = 0; l < IW; l++) begin
      check($sformatf("%s_wb_valid[%0d]", tag, l), writeback_valid[l], 0);
      check($sformatf("%s_wb_prn[%0d]", tag, l), writeback_prn[l], 0);
      check($sformatf("%s_ready[%0d]", tag, l), lane_ready[l], 1);
      check($sformatf("%s_early[%0d]", tag, l), early_wb_valid[l], 0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    pipe_flush = 1'b0;
    issue_valid      = '0;
    issue_dest_valid = '0;
    for (int l = 0; l < IW; l++) begin
      issue_dest_prn[l] = '0;
      busy_until[l]     = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 1; c <= 420; c++) begin
      @(posedge clk);
      cyc = c;
      #1;
      compare_outputs();
      if (c == 92) begin
        #1 rst_n = 1'b0;
        #1;
        check_idle("midreset");
        rst_n = 1'b1;
        sb.delete();
        for (int l = 0; l < IW; l++) busy_until[l] = 0;
      end
      apply_stimulus();
      model_update();
    end

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
